// File: rtl/arbiter_rr_vh.sv
// Round-robin arbiter sharing one resource among the vertical cores.
// Holds a grant for a multi-cycle transaction and releases it on done, on request drop or on hold timeout.

`ifndef NUM_CORE_V
`define NUM_CORE_V 10
`endif

// Per-lane priority qualifier: a lane is in the upper half of the search
// when its index is at or above the rotating pointer.
module arbiter_rr_vh_lane #(
  parameter int ID_W = 4,
  parameter int IDX  = 0
) (
  input  logic            req,
  input  logic [ID_W-1:0] ptr,
  output logic            hi
);
  assign hi = req && (IDX >= int'(ptr));
endmodule

module arbiter_rr_vh #(
  parameter int N_REQ    = `NUM_CORE_V,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt, win_id, id_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [N_REQ-1:0] hi_req, grant_nxt;
  logic             valid_nxt, timeout_nxt;
  logic             drop, hold_end;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    arbiter_rr_vh_lane #(.ID_W(ID_W), .IDX(gi)) u_lane (
      .req (req[gi]),
      .ptr (ptr),
      .hi  (hi_req[gi])
    );
  end

  // Lowest set bit at/above ptr wins; otherwise wrap to lowest set bit overall.
  always_comb begin
    win_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[i]) win_id = ID_W'(i);
    for (int i = N_REQ - 1; i >= 0; i--)
      if (hi_req[i]) win_id = ID_W'(i);
  end

  assign drop     = !req[grant_id];
  assign hold_end = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    id_nxt      = grant_id;
    valid_nxt   = grant_valid;
    timeout_nxt = 1'b0;
    ptr_nxt     = ptr;
    cnt_nxt     = hold_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt         = GRANT;
          grant_nxt         = '0;
          grant_nxt[win_id] = 1'b1;
          id_nxt            = win_id;
          valid_nxt         = 1'b1;
          cnt_nxt           = '0;
        end
      end
      GRANT: begin
        if (done || drop || hold_end) begin
          state_nxt   = GAP;
          grant_nxt   = '0;
          id_nxt      = '0;
          valid_nxt   = 1'b0;
          // done and request drop both take precedence over the timeout
          timeout_nxt = !done && !drop;
          ptr_nxt     = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end else begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      GAP: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        id_nxt    = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_id    <= id_nxt;
      grant_valid <= valid_nxt;
      timeout     <= timeout_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_arbiter_rr_vh.sv
// Directed bench for arbiter_rr_vh: per-cycle vector table plus hand sequences
// for timeout, done/timeout collision, request drop and mid-grant reset.

module tb_arbiter_rr_vh;

  localparam int N = 10;

  logic         clk, rst_n, done;
  logic [N-1:0] req, grant;
  logic         grant_valid, timeout;
  logic [3:0]   grant_id;

  int checks = 0;
  int passed = 0;
  int held;

  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic         rst;
    logic [3:0]   id;
    logic         v;
    logic         to;
  } vec_t;

  vec_t tbl[$];

  arbiter_rr_vh #(.N_REQ(N), .ID_W(4), .MAX_HOLD(255), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic add(input logic [N-1:0] r, input logic d, input logic rs,
                     input logic [3:0] id, input logic v, input logic to);
    vec_t e;
    e.req = r; e.done = d; e.rst = rs; e.id = id; e.v = v; e.to = to;
    tbl.push_back(e);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] id, input logic v, input logic to);
    logic [N-1:0] eg;
    eg = '0;
    if (v) eg[id] = 1'b1;
    chk({tag, "_grant"}, 32'(grant), 32'(eg));
    chk({tag, "_id"}, 32'(grant_id), v ? 32'(id) : 32'd0);
    chk({tag, "_valid"}, 32'(grant_valid), 32'(v));
    chk({tag, "_timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    automatic logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd9};

    // single requester core 2, done after 5 cycles, then ptr=3 picks core 3 over 2
    for (int i = 0; i < 5; i++) add(10'h004, 0, 0, 2, 1, 0);
    add(10'h004, 1, 0, 0, 0, 0);
    add(10'h00C, 0, 0, 0, 0, 0);
    add(10'h00C, 0, 0, 3, 1, 0);
    add(10'h000, 0, 0, 0, 0, 0);
    add(10'h000, 0, 0, 0, 0, 0);
    // reset, then fairness across cores 0,1,9
    add(10'h203, 0, 1, 0, 0, 0);
    for (int g = 0; g < 6; g++) begin
      for (int k = 0; k < 3; k++) add(10'h203, 0, 0, seq[g], 1, 0);
      add(10'h203, 1, 0, 0, 0, 0);
      add(10'h203, 0, 0, 0, 0, 0);
    end
    // wrap: core 9 alone, then 9 and 0 with ptr wrapped to 0
    add(10'h200, 0, 0, 9, 1, 0);
    add(10'h201, 1, 0, 0, 0, 0);
    add(10'h201, 0, 0, 0, 0, 0);
    add(10'h201, 0, 0, 0, 1, 0);
    add(10'h000, 0, 0, 0, 0, 0);
    add(10'h000, 0, 0, 0, 0, 0);

    rst_n = 1'b0; req = '0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      rst_n = !tbl[i].rst;
      req   = tbl[i].req;
      done  = tbl[i].done;
      @(posedge clk); #1;
      chk_out($sformatf("row%0d", i), tbl[i].id, tbl[i].v, tbl[i].to);
    end
    rst_n = 1'b1;

    // timeout: core 4 held for exactly 255 cycles
    req = 10'h010;
    @(posedge clk); #1;
    chk_out("to_grant", 4, 1, 0);
    held = 1;
    while (grant_valid && held < 400) begin
      @(posedge clk); #1;
      if (grant_valid) held++;
    end
    chk("to_hold_len", 32'(held), 32'd255);
    chk_out("to_pulse", 0, 0, 1);
    @(posedge clk); #1;
    chk_out("to_idle", 0, 0, 0);
    @(posedge clk); #1;
    chk_out("to_regrant", 4, 1, 0);

    // done coincides with the last hold cycle: no timeout pulse
    repeat (254) @(posedge clk);
    #1;
    chk("col_still_held", 32'(grant_valid), 32'd1);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk_out("col_release", 0, 0, 0);
    @(posedge clk); #1;
    chk_out("col_idle", 0, 0, 0);

    // requester drops mid-grant
    @(posedge clk); #1;
    chk_out("drop_grant", 4, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    req = '0;
    @(posedge clk); #1;
    chk_out("drop_release", 0, 0, 0);
    @(posedge clk); #1;
    chk_out("drop_idle", 0, 0, 0);

    // async reset while core 6 holds the grant
    req = 10'h040;
    @(posedge clk); #1;
    chk_out("rst6_grant", 6, 1, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_out("rst6_async", 0, 0, 0);
    req = 10'h042;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_out("rst6_ptr0", 1, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
